// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared types and sizing for the systolic array tile scheduler
//
// Purpose: dimension/channel widths, loop-order enum, tile descriptor layout and
//          the legacy operation/split typedefs used across the systolic array slice.
// Ports:   none (package).
package sys_array_pkg;

    localparam int DIM_W  = 16;
    localparam int NUM_CH = 2;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        K_INNER = 1'b0,
        M_INNER = 1'b1
    } loop_order_e;

    typedef enum logic [1:0] {
        OP_MATMUL     = 2'd0,
        OP_MATMUL_ACC = 2'd1,
        OP_BYPASS     = 2'd2
    } operation_types;

    typedef enum logic [1:0] {
        SPLIT_NONE = 2'd0,
        SPLIT_M    = 2'd1,
        SPLIT_K    = 2'd2,
        SPLIT_N    = 2'd3
    } split_type;

    typedef struct packed {
        logic [DIM_W-1:0] m0;
        logic [DIM_W-1:0] k0;
        logic [DIM_W-1:0] n0;
        logic [DIM_W-1:0] m_sz;
        logic [DIM_W-1:0] k_sz;
        logic [DIM_W-1:0] n_sz;
        logic             acc;
        logic             last_k;
        logic [CH_W-1:0]  ch;
        logic [31:0]      idx;
    } tile_desc_t;

    // Tile size along one axis: the remaining extent, capped at the array limit.
    function automatic logic [DIM_W-1:0] clip_dim(input logic [DIM_W-1:0] rem, input int max);
        return (rem > DIM_W'(max)) ? DIM_W'(max) : rem;
    endfunction

endpackage

// File: rtl/sys_array_tile_axis.sv
// rtl/sys_array_tile_axis.sv - one loop axis of the tile scheduler (offset/size with wrap)
//
// Purpose: walks one matrix dimension in steps of MAX, presenting the current tile
//          offset and size. Edge tiles are shortened to the remaining extent.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clr_i         reload offset 0 / first size from dim_i
//   inc_i         advance to the next tile (wraps to 0 when wrap_o is high)
//   dim_i         latched extent of this dimension
//   off_o, sz_o   current tile offset and size
//   wrap_o        current tile is the last one on this axis
module sys_array_tile_axis
    import sys_array_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [DIM_W-1:0] dim_i,
    output logic [DIM_W-1:0] off_o,
    output logic [DIM_W-1:0] sz_o,
    output logic             wrap_o
);

    logic [DIM_W-1:0] off_q, off_d;
    logic [DIM_W-1:0] sz_q, sz_d;
    logic [DIM_W:0]   step_w;

    // One extra bit so offset + MAX cannot overflow near the top of the range.
    assign step_w = {1'b0, off_q} + (DIM_W+1)'(MAX);
    assign wrap_o = (step_w >= {1'b0, dim_i});

    always_comb begin
        off_d = off_q;
        sz_d  = sz_q;
        if (clr_i || (inc_i && wrap_o)) begin
            off_d = '0;
            sz_d  = clip_dim(dim_i, MAX);
        end else if (inc_i) begin
            // Not wrapping implies step_w < dim_i, so the truncation is exact.
            off_d = step_w[DIM_W-1:0];
            sz_d  = clip_dim(dim_i - step_w[DIM_W-1:0], MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q <= '0;
            sz_q  <= '0;
        end else begin
            off_q <= off_d;
            sz_q  <= sz_d;
        end
    end

    assign off_o = off_q;
    assign sz_o  = sz_q;

endmodule

// File: rtl/sys_array_tile_sched.sv
// rtl/sys_array_tile_sched.sv - streaming tile scheduler for C = A x W on the systolic arrays
//
// Purpose: splits an M x K x N matmul into array-sized tiles and hands them out one per
//          valid/ready handshake, round-robin over NUM_CH arrays.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     job request, sampled only when idle
//   cfg_a_w/a_l/w_w/w_l       M, K, rows of W (must equal K), N
//   cfg_order                 0 = K innermost (n,m,k), 1 = M innermost (n,k,m)
//   busy                      job in progress, through the done cycle
//   tile_valid/tile_ready     descriptor handshake
//   tile                      current tile descriptor
//   done, err                 end-of-job pulse, illegal-config flag
//   tile_count                tiles handshaken in the current/last job
module sys_array_tile_sched
    import sys_array_pkg::*;
#(
    parameter int ARRAY_MAX_W   = 4,
    parameter int ARRAY_MAX_L   = 4,
    parameter int ARRAY_MAX_A_L = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_a_w,
    input  logic [DIM_W-1:0] cfg_a_l,
    input  logic [DIM_W-1:0] cfg_w_w,
    input  logic [DIM_W-1:0] cfg_w_l,
    input  logic             cfg_order,
    output logic             busy,
    output logic             tile_valid,
    input  logic             tile_ready,
    output tile_desc_t       tile,
    output logic             done,
    output logic             err,
    output logic [31:0]      tile_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EMIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    state_e           state_q;
    logic [DIM_W-1:0] m_dim_q, k_dim_q, w_dim_q, n_dim_q;
    loop_order_e      order_q;
    logic             busy_q, tile_valid_q, done_q, err_q;
    logic [31:0]      tile_count_q;
    logic [CH_W-1:0]  ch_q;

    logic             hs;
    logic             clr_axes;
    logic             cfg_bad;
    logic             last_tile;
    logic             inc_m, inc_k, inc_n;
    logic             wrap_m, wrap_k, wrap_n;
    logic [DIM_W-1:0] m_off, k_off, n_off;
    logic [DIM_W-1:0] m_sz, k_sz, n_sz;
    tile_desc_t       desc;

    assign hs        = tile_valid_q && tile_ready;
    assign clr_axes  = (state_q == ST_CHECK);
    assign cfg_bad   = (m_dim_q == '0) || (k_dim_q == '0) || (w_dim_q == '0) ||
                       (n_dim_q == '0) || (w_dim_q != k_dim_q);
    // n is always outermost, so the job ends only when every axis is on its last tile.
    assign last_tile = wrap_m && wrap_k && wrap_n;

    // Carry chain: the innermost axis steps on every handshake, outer axes on inner wrap.
    always_comb begin
        inc_m = 1'b0;
        inc_k = 1'b0;
        inc_n = 1'b0;
        if (order_q == K_INNER) begin
            inc_k = hs;
            inc_m = hs && wrap_k;
            inc_n = hs && wrap_k && wrap_m;
        end else begin
            inc_m = hs;
            inc_k = hs && wrap_m;
            inc_n = hs && wrap_m && wrap_k;
        end
    end

    sys_array_tile_axis #(.MAX(ARRAY_MAX_A_L)) u_axis_m (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_axes),
        .inc_i   (inc_m),
        .dim_i   (m_dim_q),
        .off_o   (m_off),
        .sz_o    (m_sz),
        .wrap_o  (wrap_m)
    );

    sys_array_tile_axis #(.MAX(ARRAY_MAX_W)) u_axis_k (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_axes),
        .inc_i   (inc_k),
        .dim_i   (k_dim_q),
        .off_o   (k_off),
        .sz_o    (k_sz),
        .wrap_o  (wrap_k)
    );

    sys_array_tile_axis #(.MAX(ARRAY_MAX_L)) u_axis_n (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_axes),
        .inc_i   (inc_n),
        .dim_i   (n_dim_q),
        .off_o   (n_off),
        .sz_o    (n_sz),
        .wrap_o  (wrap_n)
    );

    // Descriptor is built only from registers, so it is stable while stalled.
    // Gated by tile_valid so the bus reads all-zero outside EMIT.
    always_comb begin
        desc = '0;
        if (tile_valid_q) begin
            desc.m0     = m_off;
            desc.k0     = k_off;
            desc.n0     = n_off;
            desc.m_sz   = m_sz;
            desc.k_sz   = k_sz;
            desc.n_sz   = n_sz;
            desc.acc    = (k_off != '0);
            desc.last_k = (({1'b0, k_off} + {1'b0, k_sz}) == {1'b0, k_dim_q});
            desc.ch     = ch_q;
            desc.idx    = tile_count_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            m_dim_q      <= '0;
            k_dim_q      <= '0;
            w_dim_q      <= '0;
            n_dim_q      <= '0;
            order_q      <= K_INNER;
            busy_q       <= 1'b0;
            tile_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tile_count_q <= '0;
            ch_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_dim_q      <= cfg_a_w;
                        k_dim_q      <= cfg_a_l;
                        w_dim_q      <= cfg_w_w;
                        n_dim_q      <= cfg_w_l;
                        order_q      <= loop_order_e'(cfg_order);
                        busy_q       <= 1'b1;
                        tile_count_q <= '0;
                        ch_q         <= '0;
                        state_q      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cfg_bad) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        tile_valid_q <= 1'b1;
                        state_q      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (hs) begin
                        tile_count_q <= tile_count_q + 32'd1;
                        ch_q         <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                        if (last_tile) begin
                            tile_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign tile_valid = tile_valid_q;
    assign tile       = desc;
    assign done       = done_q;
    assign err        = err_q;
    assign tile_count = tile_count_q;

endmodule

// File: tb/tb_sys_array_tile_sched.sv
// tb/tb_sys_array_tile_sched.sv - scoreboard bench for the systolic array tile scheduler
module tb_sys_array_tile_sched;
    import sys_array_pkg::*;

    localparam int TMAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] cfg_a_w, cfg_a_l, cfg_w_w, cfg_w_l;
    logic        cfg_order;
    logic        busy, tile_valid, tile_ready, done, err;
    tile_desc_t  tile;
    logic [31:0] tile_count;

    int          n_checks = 0;
    int          n_errors = 0;
    tile_desc_t  sb[$];
    tile_desc_t  held;
    tile_desc_t  snap;
    bit          stall = 1'b0;
    int          cyc;

    always #5 clk = ~clk;

    sys_array_tile_sched #(
        .ARRAY_MAX_W   (4),
        .ARRAY_MAX_L   (4),
        .ARRAY_MAX_A_L (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cfg_a_w    (cfg_a_w),
        .cfg_a_l    (cfg_a_l),
        .cfg_w_w    (cfg_w_w),
        .cfg_w_l    (cfg_w_l),
        .cfg_order  (cfg_order),
        .busy       (busy),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile       (tile),
        .done       (done),
        .err        (err),
        .tile_count (tile_count)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void add_tile(input int m0, input int k0, input int n0,
                                     input int M, input int K, input int N, inout int idx);
        tile_desc_t d;
        d        = '0;
        d.m0     = 16'(m0);
        d.k0     = 16'(k0);
        d.n0     = 16'(n0);
        d.m_sz   = 16'(imin(TMAX, M - m0));
        d.k_sz   = 16'(imin(TMAX, K - k0));
        d.n_sz   = 16'(imin(TMAX, N - n0));
        d.acc    = (k0 != 0);
        d.last_k = (k0 + imin(TMAX, K - k0) == K);
        d.ch     = CH_W'(idx % 2);
        d.idx    = 32'(idx);
        sb.push_back(d);
        idx++;
    endfunction

    // Expected tile stream for a legal job, in loop-nest order.
    function automatic void model_push(input int M, input int K, input int N, input bit ord);
        int idx = 0;
        for (int n0 = 0; n0 < N; n0 += TMAX)
            if (!ord) begin
                for (int m0 = 0; m0 < M; m0 += TMAX)
                    for (int k0 = 0; k0 < K; k0 += TMAX)
                        add_tile(m0, k0, n0, M, K, N, idx);
            end else begin
                for (int k0 = 0; k0 < K; k0 += TMAX)
                    for (int m0 = 0; m0 < M; m0 += TMAX)
                        add_tile(m0, k0, n0, M, K, N, idx);
            end
    endfunction

    // Handshake monitor: pops the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("bp_valid_held", 160'(tile_valid), 160'(1));
                chk("bp_tile_stable", 160'(tile), 160'(held));
            end
            if (tile_valid && tile_ready) begin
                if (sb.size() == 0) chk("sb_tile_unexpected", 160'(sb.size()), 160'(1));
                else chk("tile", 160'(tile), 160'(sb.pop_front()));
            end
            stall = tile_valid && !tile_ready;
            held  = tile;
        end
    end

    // Drives start at cycle t; returns 1ns into cycle t+2 after the t+1/t+2 timing checks.
    task automatic do_start(input int m, input int k, input int w, input int n,
                            input bit ord, input bit legal);
        @(posedge clk); #1;
        start = 1'b1; cfg_a_w = 16'(m); cfg_a_l = 16'(k); cfg_w_w = 16'(w);
        cfg_w_l = 16'(n); cfg_order = ord;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_a_w = 16'($urandom); cfg_a_l = 16'($urandom); cfg_w_w = 16'($urandom);
        cfg_w_l = 16'($urandom); cfg_order = 1'($urandom);
        chk("busy_t1", 160'(busy), 160'(1));
        chk("valid_t1", 160'(tile_valid), 160'(0));
        chk("count_clr_t1", 160'(tile_count), 160'(0));
        @(posedge clk); #1;
        if (legal) begin
            chk("valid_t2", 160'(tile_valid), 160'(1));
        end else begin
            chk("bad_valid_t2", 160'(tile_valid), 160'(0));
            chk("bad_done_t2", 160'(done), 160'(1));
            chk("bad_err_t2", 160'(err), 160'(1));
            chk("bad_count_t2", 160'(tile_count), 160'(0));
            @(posedge clk); #1;
            chk("bad_done_t3", 160'(done), 160'(0));
            chk("bad_busy_t3", 160'(busy), 160'(0));
        end
    endtask

    task automatic wait_done(input bit rnd, output int c);
        bit got = 1'b0;
        c = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            c++;
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                if (rnd) tile_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!got) chk("done_timeout", 160'(got), 160'(1));
    endtask

    // Called at the negedge of the done cycle.
    task automatic finish_job(input int ntiles);
        chk("job_err", 160'(err), 160'(0));
        chk("job_busy_at_done", 160'(busy), 160'(1));
        chk("job_count", 160'(tile_count), 160'(ntiles));
        chk("sb_drained", 160'(sb.size()), 160'(0));
        @(posedge clk); #1;
        chk("job_done_pulse", 160'(done), 160'(0));
        chk("job_busy_after", 160'(busy), 160'(0));
        chk("job_count_hold", 160'(tile_count), 160'(ntiles));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; tile_ready = 1'b0; cfg_order = 1'b0;
        cfg_a_w = '0; cfg_a_l = '0; cfg_w_w = '0; cfg_w_l = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_valid", 160'(tile_valid), 160'(0));
        chk("rst_done", 160'(done), 160'(0));
        chk("rst_err", 160'(err), 160'(0));
        chk("rst_count", 160'(tile_count), 160'(0));
        chk("rst_tile", 160'(tile), 160'(0));
        reset_n = 1'b1;

        // Basic: K split into 4 + 1
        tile_ready = 1'b1;
        model_push(2, 5, 2, 1'b0);
        do_start(2, 5, 5, 2, 1'b0, 1'b1);
        wait_done(1'b0, cyc);
        chk("t1_cycles", 160'(cyc), 160'(3));
        finish_job(2);

        // M-inner order with edge tiles, full rate
        model_push(9, 4, 8, 1'b1);
        do_start(9, 4, 4, 8, 1'b1, 1'b1);
        wait_done(1'b0, cyc);
        chk("t2_cycles", 160'(cyc), 160'(7));
        finish_job(6);

        // Directed 3-cycle stall on the first tile
        tile_ready = 1'b0;
        model_push(2, 5, 2, 1'b0);
        do_start(2, 5, 5, 2, 1'b0, 1'b1);
        snap = tile;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 160'(tile_valid), 160'(1));
            chk("stall_tile", 160'(tile), 160'(snap));
        end
        @(posedge clk); #1;
        tile_ready = 1'b1;
        wait_done(1'b0, cyc);
        finish_job(2);

        // Random backpressure, K-inner order
        tile_ready = 1'b0;
        model_push(9, 6, 8, 1'b0);
        do_start(9, 6, 6, 8, 1'b0, 1'b1);
        wait_done(1'b1, cyc);
        finish_job(12);
        tile_ready = 1'b1;

        // Illegal configs
        do_start(4, 5, 3, 4, 1'b0, 1'b0);
        do_start(0, 4, 4, 4, 1'b1, 1'b0);

        // Reset mid-job after three tiles
        model_push(9, 4, 8, 1'b1);
        do_start(9, 4, 4, 8, 1'b1, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 160'(busy), 160'(0));
        chk("mid_rst_valid", 160'(tile_valid), 160'(0));
        chk("mid_rst_done", 160'(done), 160'(0));
        chk("mid_rst_count", 160'(tile_count), 160'(0));
        chk("mid_rst_tile", 160'(tile), 160'(0));
        chk("sb_left_at_rst", 160'(sb.size()), 160'(3));
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_in_rst", 160'(done), 160'(0));
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Full job after reset; a start pulse mid-job must be ignored
        model_push(9, 4, 8, 1'b1);
        do_start(9, 4, 4, 8, 1'b1, 1'b1);
        start = 1'b1; cfg_a_w = 16'd1; cfg_a_l = 16'd1; cfg_w_w = 16'd1; cfg_w_l = 16'd1;
        cfg_order = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, cyc);
        finish_job(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_queued_start_busy", 160'(busy), 160'(0));
            chk("no_queued_start_valid", 160'(tile_valid), 160'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
